// File: rtl/rect_pkg.sv
// Shared definitions for the rectified-frame DDR writer/reader pair:
// command codes, cmd/addr beat field layout and the read-side FSM states.
package rect_pkg;

  localparam logic DDR_CMD_RD = 1'b1;
  localparam logic DDR_CMD_WR = 1'b0;

  localparam int LINE_BYTES = 640;

  // Command beat: {22'b0, last, rd_wrn, len[7:0]}
  localparam int CMD_LEN_LSB   = 0;
  localparam int CMD_LEN_W     = 8;
  localparam int CMD_RDWRN_BIT = 8;
  localparam int CMD_LAST_BIT  = 9;

  // Address beat: {base[11:0], lr, addr_x[18:0]}
  localparam int ADDR_X_W      = 19;
  localparam int ADDR_LR_BIT   = 19;
  localparam int ADDR_BASE_LSB = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } ibuf_state_t;

  function automatic logic [31:0] cmd_beat(input logic last, input logic rd_wrn,
                                           input logic [CMD_LEN_W-1:0] len);
    logic [31:0] beat;
    beat = '0;
    beat[CMD_LAST_BIT] = last;
    beat[CMD_RDWRN_BIT] = rd_wrn;
    beat[CMD_LEN_LSB +: CMD_LEN_W] = len;
    return beat;
  endfunction

  function automatic logic [31:0] addr_beat(input logic [11:0] base, input logic lr,
                                            input logic [ADDR_X_W-1:0] addr_x);
    logic [31:0] beat;
    beat = '0;
    beat[ADDR_BASE_LSB +: 12] = base;
    beat[ADDR_LR_BIT] = lr;
    beat[0 +: ADDR_X_W] = addr_x;
    return beat;
  endfunction

endpackage

// File: rtl/rect_ibuf_dff.sv
// Synchronous show-ahead FIFO with occupancy count; head word is visible on
// rd_data whenever empty is low. srst flushes the pointers in one cycle.
module rect_ibuf_dff #(
  parameter int WIDTH = 35,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // Storage is not reset; pointer flush alone makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (data_count == (AW+1)'(2**AW));
  assign empty   = (data_count == '0);

endmodule

// File: rtl/rect_ibuf.sv
// DDR read-side streamer: fetches one rectified L/R frame in fixed bursts and
// presents it as a 32-bit word stream with line/frame markers.
module rect_ibuf #(
  parameter int BURST_WORDS = 32,
  parameter int LINE_WORDS  = 160,
  parameter int NUM_LINES   = 480,
  parameter int FIFO_AW     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enb,
  input  logic        start,
  input  logic        lr,
  input  logic [11:0] base_a,
  input  logic [11:0] base_b,
  output logic        busy,
  output logic        frm_end,
  output logic        ovf,
  output logic        ddr_req,
  input  logic        ddr_ack,
  output logic [31:0] ddr_dout,
  output logic [3:0]  ddr_strb,
  output logic        ddr_vout,
  input  logic [31:0] ddr_din,
  input  logic        ddr_vin,
  output logic [31:0] dout,
  output logic        dout_sol,
  output logic        dout_eol,
  output logic        dout_eof,
  output logic        dout_vld,
  input  logic        dout_rdy
);

  import rect_pkg::*;

  localparam int X_BURSTS = LINE_WORDS / BURST_WORDS;
  localparam int X_MAX    = X_BURSTS - 1;
  localparam int Y_MAX    = NUM_LINES - 1;
  localparam int X_W      = (X_BURSTS > 1) ? $clog2(X_BURSTS) : 1;
  localparam int Y_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int BEAT_W   = $clog2(BURST_WORDS);
  localparam logic [FIFO_AW:0] CREDIT = (FIFO_AW+1)'(2**FIFO_AW - BURST_WORDS);

  ibuf_state_t state, state_nxt;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [BEAT_W-1:0]   beat;
  logic                frame_cnt;
  logic                lr_q;
  logic [ADDR_X_W-1:0] addr_x;
  logic                last_burst;
  logic                last_beat;
  logic                x_at_max;

  logic                fifo_wr;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_AW:0]    fifo_count;
  logic [34:0]         fifo_wdata;
  logic [34:0]         fifo_rdata;
  logic                w_sol;
  logic                w_eol;
  logic                w_eof;

  assign x_at_max   = (x == X_W'(X_MAX));
  assign last_burst = x_at_max && (y == Y_W'(Y_MAX));
  assign last_beat  = (beat == BEAT_W'(BURST_WORDS - 1));

  always_comb begin
    state_nxt = state;
    ddr_vout  = 1'b0;
    ddr_dout  = '0;
    ddr_strb  = 4'hF;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CHK;
      ST_CHK:  if (fifo_count <= CREDIT) state_nxt = ST_REQ;
      ST_REQ: begin
        if (ddr_ack) begin
          state_nxt = ST_ADDR;
          ddr_vout  = 1'b1;
          ddr_strb  = 4'h0;
          ddr_dout  = cmd_beat(last_burst, DDR_CMD_RD, CMD_LEN_W'(BURST_WORDS - 1));
        end
      end
      ST_ADDR: begin
        state_nxt = ST_DATA;
        ddr_vout  = 1'b1;
        ddr_strb  = 4'h0;
        ddr_dout  = addr_beat(frame_cnt ? base_b : base_a, lr_q, addr_x);
      end
      ST_DATA: if (ddr_vin && last_beat) state_nxt = ST_DONE;
      ST_DONE: state_nxt = last_burst ? ST_IDLE : ST_CHK;
      default: state_nxt = ST_IDLE;
    endcase
    if (!enb) state_nxt = ST_IDLE;
  end

  // ddr_req is a registered copy of "next state holds the arbiter port".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ddr_req <= 1'b0;
      frm_end <= 1'b0;
    end else begin
      state   <= state_nxt;
      ddr_req <= (state_nxt == ST_REQ) || (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
      frm_end <= enb && (state == ST_DONE) && last_burst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      beat      <= '0;
      frame_cnt <= 1'b0;
      lr_q      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!enb) begin
      x         <= '0;
      y         <= '0;
      beat      <= '0;
      frame_cnt <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) lr_q <= lr;
      if (state == ST_DATA && ddr_vin) begin
        beat <= last_beat ? '0 : beat + 1'b1;
        if (fifo_full) ovf <= 1'b1;
      end
      if (state == ST_DONE) begin
        if (x_at_max) begin
          x <= '0;
          y <= (y == Y_W'(Y_MAX)) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
        if (last_burst) frame_cnt <= ~frame_cnt;
      end
    end
  end

  // Recomputed every cycle; x/y change only in DONE, so it is stable by REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_x <= '0;
    else        addr_x <= ADDR_X_W'(y) * ADDR_X_W'(LINE_BYTES)
                        + ADDR_X_W'(x) * ADDR_X_W'(4 * BURST_WORDS);
  end

  assign w_sol      = (x == '0) && (beat == '0);
  assign w_eol      = x_at_max && last_beat;
  assign w_eof      = w_eol && (y == Y_W'(Y_MAX));
  assign fifo_wdata = {w_eof, w_eol, w_sol, ddr_din};
  assign fifo_wr    = (state == ST_DATA) && ddr_vin && !fifo_full;

  rect_ibuf_dff #(
    .WIDTH (35),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .srst       (~enb),
    .wr_en      (fifo_wr),
    .wr_data    (fifo_wdata),
    .rd_en      (dout_rdy),
    .rd_data    (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .data_count (fifo_count)
  );

  assign busy     = (state != ST_IDLE);
  assign dout     = fifo_rdata[31:0];
  assign dout_sol = fifo_rdata[32];
  assign dout_eol = fifo_rdata[33];
  assign dout_eof = fifo_rdata[34];
  assign dout_vld = ~fifo_empty;

endmodule

// File: tb/tb_rect_ibuf.sv
// Directed bench for rect_ibuf: a 2-line frame keeps runs short while the
// burst, line and FIFO geometry stay at their production values.
module tb_rect_ibuf;

  localparam int BW          = 32;
  localparam int LW          = 160;
  localparam int NL          = 2;
  localparam int AW          = 8;
  localparam int FRAME_WORDS = LW * NL;
  localparam int BURSTS      = (LW / BW) * NL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enb = 1'b1;
  logic        start = 1'b0;
  logic        lr = 1'b0;
  logic [11:0] base_a = 12'h100;
  logic [11:0] base_b = 12'h2AB;
  logic        busy, frm_end, ovf, ddr_req, ddr_vout;
  logic        ddr_ack = 1'b0;
  logic [31:0] ddr_dout;
  logic [3:0]  ddr_strb;
  logic [31:0] ddr_din = '0;
  logic        ddr_vin = 1'b0;
  logic [31:0] dout;
  logic        dout_sol, dout_eol, dout_eof, dout_vld;
  logic        dout_rdy = 1'b1;

  int errors = 0;
  int checks = 0;
  int prod_words = 0;
  int mon_words = 0, mon_total = 0, mon_sol = 0, mon_eol = 0, mon_eof = 0;
  int mon_bad = 0, mon_frm = 0;

  always #5 clk = ~clk;

  rect_ibuf #(
    .BURST_WORDS (BW),
    .LINE_WORDS  (LW),
    .NUM_LINES   (NL),
    .FIFO_AW     (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enb      (enb),
    .start    (start),
    .lr       (lr),
    .base_a   (base_a),
    .base_b   (base_b),
    .busy     (busy),
    .frm_end  (frm_end),
    .ovf      (ovf),
    .ddr_req  (ddr_req),
    .ddr_ack  (ddr_ack),
    .ddr_dout (ddr_dout),
    .ddr_strb (ddr_strb),
    .ddr_vout (ddr_vout),
    .ddr_din  (ddr_din),
    .ddr_vin  (ddr_vin),
    .dout     (dout),
    .dout_sol (dout_sol),
    .dout_eol (dout_eol),
    .dout_eof (dout_eof),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  // Stream consumer: words carry their in-frame index in the low 16 bits.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (!enb) begin
        mon_words = 0;
      end else if (dout_vld && dout_rdy) begin
        if (dout !== {8'hA5, 8'h00, 16'(mon_words)}) mon_bad++;
        if (dout_sol !== 1'(mon_words % LW == 0)) mon_bad++;
        if (dout_eol !== 1'(mon_words % LW == LW - 1)) mon_bad++;
        if (dout_eof !== 1'(mon_words == FRAME_WORDS - 1)) mon_bad++;
        if (dout_sol) mon_sol++;
        if (dout_eol) mon_eol++;
        if (dout_eof) mon_eof++;
        mon_total++;
        mon_words = (mon_words == FRAME_WORDS - 1) ? 0 : mon_words + 1;
      end
      if (frm_end) mon_frm++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_lr);
    start = s_start;
    lr    = s_lr;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_cmd(input int k);
    return (k == BURSTS - 1) ? 32'h0000_031F : 32'h0000_011F;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [11:0] base, input logic l, input int k);
    int xx = k % (LW / BW);
    int yy = k / (LW / BW);
    return {base, l, 19'(yy * 640 + xx * 4 * BW)};
  endfunction

  // Arbiter/DDR model: grant, check cmd+addr beats, then return data beats.
  // A junk vin is offered in REQ and ADDR; the DUT must drop both.
  task automatic serve_burst(input logic [31:0] e_cmd, input logic [31:0] e_addr, input int beats);
    int n = 0;
    while (ddr_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_wait", 32'(ddr_req), 32'd1);
    if (ddr_req !== 1'b1) return;
    ddr_vin = 1'b1;
    ddr_din = 32'hDEAD_BEEF;
    @(negedge clk);
    ddr_vin = 1'b0;
    ddr_ack = 1'b1;
    #1;
    checkOutput("cmd_vout", 32'(ddr_vout), 32'd1);
    checkOutput("cmd_strb", 32'(ddr_strb), 32'h0);
    checkOutput("cmd_beat", ddr_dout, e_cmd);
    @(negedge clk);
    ddr_ack = 1'b0;
    ddr_vin = 1'b1;
    ddr_din = 32'hDEAD_BEEF;
    #1;
    checkOutput("addr_vout", 32'(ddr_vout), 32'd1);
    checkOutput("addr_beat", ddr_dout, e_addr);
    @(negedge clk);
    for (int b = 0; b < beats; b++) begin
      ddr_vin = 1'b1;
      ddr_din = {8'hA5, 8'h00, 16'(prod_words)};
      prod_words++;
      if (b == 0) begin
        #1;
        checkOutput("data_strb", 32'(ddr_strb), 32'hF);
        checkOutput("data_vout", 32'(ddr_vout), 32'd0);
      end
      @(negedge clk);
    end
    ddr_vin = 1'b0;
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (frm_end !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frm_end", 32'(frm_end), 32'd1);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("frm_end_pulse", 32'(frm_end), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (dout_vld === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drained", 32'(dout_vld), 32'd0);
  endtask

  initial begin
    int req_hi;

    repeat (3) @(negedge clk);
    checkOutput("rst_req", 32'(ddr_req), 32'd0);
    checkOutput("rst_vout", 32'(ddr_vout), 32'd0);
    checkOutput("rst_dout", ddr_dout, 32'h0);
    checkOutput("rst_strb", 32'(ddr_strb), 32'hF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frm_end", 32'(frm_end), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_vld", 32'(dout_vld), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read data while idle must not reach the FIFO.
    ddr_vin = 1'b1;
    ddr_din = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    ddr_vin = 1'b0;
    @(negedge clk);
    checkOutput("idle_vin_vld", 32'(dout_vld), 32'd0);

    // Frame 0: left, base_a, consumer always ready.
    prod_words = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_req_c1", 32'(ddr_req), 32'd0);
    @(negedge clk);
    checkOutput("start_req_c2", 32'(ddr_req), 32'd1);
    serve_burst(32'h0000_011F, 32'h1000_0000, BW);
    for (int k = 1; k < BURSTS; k++) serve_burst(exp_cmd(k), exp_addr(12'h100, 1'b0, k), BW);
    wait_frame_end();
    drain();
    checkOutput("f0_words", 32'(mon_total), 32'd320);
    checkOutput("f0_sol", 32'(mon_sol), 32'd2);
    checkOutput("f0_eol", 32'(mon_eol), 32'd2);
    checkOutput("f0_eof", 32'(mon_eof), 32'd1);
    checkOutput("f0_frm_end", 32'(mon_frm), 32'd1);

    // Frame 1: right, ping-pongs to base_b; last burst is x=4,y=1.
    prod_words = 0;
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < BURSTS - 1; k++) serve_burst(exp_cmd(k), exp_addr(12'h2AB, 1'b1, k), BW);
    serve_burst(32'h0000_031F, 32'h2AB8_0480, BW);
    wait_frame_end();
    drain();
    checkOutput("f1_words", 32'(mon_total), 32'd640);
    checkOutput("f1_eof", 32'(mon_eof), 32'd2);

    // Frame 2: consumer stalled; credit stops fetching once 256 words are held.
    dout_rdy = 1'b0;
    prod_words = 0;
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) serve_burst(exp_cmd(k), exp_addr(12'h100, 1'b0, k), BW);
    req_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ddr_req !== 1'b0) req_hi++;
    end
    checkOutput("stall_req", 32'(req_hi), 32'd0);
    checkOutput("stall_busy", 32'(busy), 32'd1);
    checkOutput("stall_ovf", 32'(ovf), 32'd0);
    checkOutput("stall_vld", 32'(dout_vld), 32'd1);
    checkOutput("stall_head", dout, 32'hA500_0000);
    checkOutput("stall_sol", 32'(dout_sol), 32'd1);
    checkOutput("stall_consumed", 32'(mon_total), 32'd640);
    dout_rdy = 1'b1;
    for (int k = 8; k < BURSTS; k++) serve_burst(exp_cmd(k), exp_addr(12'h100, 1'b0, k), BW);
    wait_frame_end();
    drain();
    checkOutput("f2_words", 32'(mon_total), 32'd960);
    checkOutput("f2_eof", 32'(mon_eof), 32'd3);

    // Abort mid-DATA after 10 beats, then refetch from the top of base_a.
    prod_words = 0;
    applyStimulus(1'b1, 1'b0);
    serve_burst(exp_cmd(0), exp_addr(12'h2AB, 1'b0, 0), 10);
    enb = 1'b0;
    @(negedge clk);
    checkOutput("abort_req", 32'(ddr_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_vld", 32'(dout_vld), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    enb = 1'b1;
    @(negedge clk);
    prod_words = 0;
    applyStimulus(1'b1, 1'b0);
    serve_burst(32'h0000_011F, 32'h1000_0000, BW);
    for (int k = 1; k < BURSTS; k++) serve_burst(exp_cmd(k), exp_addr(12'h100, 1'b0, k), BW);
    wait_frame_end();
    drain();
    checkOutput("f3_eof", 32'(mon_eof), 32'd4);
    checkOutput("frm_end_total", 32'(mon_frm), 32'd4);
    checkOutput("stream_order", 32'(mon_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
